// File: rtl/mdio_master_cfg.sv
// MDIO management master: free-running MDC divider plus a Clause 22 / Clause 45
// frame serialiser driven by a command/response handshake.
module mdio_master_cfg #(
  parameter int MDC_DIV       = 2,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk_8_3mhz,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);
  localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int IW = 7;
  localparam logic [DW-1:0] DIV_LAST = DW'(MDC_DIV - 1);
  localparam logic [IW-1:0] PB_L     = IW'(PREAMBLE_BITS);
  localparam logic [IW-1:0] TA0_L    = IW'(PREAMBLE_BITS + 14);
  localparam logic [IW-1:0] TA1_L    = IW'(PREAMBLE_BITS + 15);
  localparam logic [IW-1:0] D0_L     = IW'(PREAMBLE_BITS + 16);
  localparam logic [IW-1:0] LAST_L   = IW'(PREAMBLE_BITS + 31);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_SHIFT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            mdc_q, mdc_d;
  logic            in_q;
  logic [IW-1:0]   idx_q, idx_d, nxt_idx;
  logic [31:0]     frame_q, frame_d;
  logic            rd_q, rd_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            ta_err_q, ta_err_d;
  logic            out_q, out_d, oe_q, oe_d;
  logic            rv_q, rv_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            tick, fall_tick, rise_tick, present;

  assign tick      = (div_q == DIV_LAST);
  assign fall_tick = tick & mdc_q;
  assign rise_tick = tick & ~mdc_q;
  // A new bit goes out on every MDC fall from ALIGN, or from SHIFT unless the last bit just ended.
  assign present   = fall_tick & ((state_q == S_ALIGN) | ((state_q == S_SHIFT) & (idx_q != LAST_L)));
  assign nxt_idx   = (state_q == S_ALIGN) ? '0 : idx_q + 1'b1;

  // Next-state: divider, frame sequencing, read sampling and response capture.
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    mdc_d      = tick ? ~mdc_q : mdc_q;
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    ta_err_d   = ta_err_q;
    out_d      = out_q;
    oe_d       = oe_q;
    rv_d       = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        // ST, OP, PHYAD, REGAD, TA=10, DATA; preamble is generated from the index.
        frame_d  = {1'b0, ~cmd_c45, cmd_op, cmd_phyad, cmd_regad, 2'b10, cmd_wdata};
        rd_d     = cmd_op[1];
        rdata_d  = '0;
        ta_err_d = 1'b0;
        if (!cmd_c45 && (cmd_op == 2'b00 || cmd_op == 2'b11)) begin
          state_d    = S_DONE;
          rv_d       = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: if (fall_tick) state_d = S_SHIFT;
      S_SHIFT: begin
        if (rise_tick && rd_q && idx_q == TA1_L) ta_err_d = in_q;
        if (rise_tick && rd_q && idx_q >= D0_L)  rdata_d  = {rdata_q[14:0], in_q};
        if (fall_tick && idx_q == LAST_L) begin
          state_d    = S_DONE;
          out_d      = 1'b1;
          oe_d       = 1'b0;
          rv_d       = 1'b1;
          rsp_data_d = rd_q ? rdata_q : '0;
          rsp_err_d  = rd_q & ta_err_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (present) begin
      idx_d = nxt_idx;
      oe_d  = ~rd_q | (nxt_idx < TA0_L);
      if (nxt_idx < PB_L) begin
        out_d = 1'b1;
      end else begin
        out_d   = oe_d ? frame_q[31] : 1'b1;
        frame_d = {frame_q[30:0], 1'b0};
      end
    end
  end

  // State and registered outputs; reset releases the pad immediately.
  always_ff @(posedge clk_8_3mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      mdc_q      <= 1'b0;
      in_q       <= 1'b1;
      idx_q      <= '0;
      frame_q    <= '0;
      rd_q       <= 1'b0;
      rdata_q    <= '0;
      ta_err_q   <= 1'b0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      rv_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      mdc_q      <= mdc_d;
      in_q       <= mdio_in;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      ta_err_q   <= ta_err_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      rv_q       <= rv_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_ALIGN) | (state_q == S_SHIFT);
  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mdio_master_cfg.sv
// Bench for mdio_master_cfg: two instances (default and PREAMBLE_BITS=0/MDC_DIV=4)
// checked against a frame-level reference model with a PHY responder.
module tb_mdio_master_cfg;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_c45 = 1'b0, mdio_in = 1'b1;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_phyad = '0, cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  bit          sel = 1'b0;
  int          n_tests = 0, n_fail = 0;

  logic        rdy0, rv0, err0, busy0, mdc0, mo0, oe0;
  logic        rdy1, rv1, err1, busy1, mdc1, mo1, oe1;
  logic [15:0] rd0, rd1;

  mdio_master_cfg u_dut0 (
    .clk_8_3mhz(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(rdy0),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv0), .rsp_data(rd0), .rsp_err(err0), .busy(busy0),
    .mdc(mdc0), .mdio_out(mo0), .mdio_oe(oe0), .mdio_in(mdio_in));

  mdio_master_cfg #(.MDC_DIV(4), .PREAMBLE_BITS(0)) u_dut1 (
    .clk_8_3mhz(clk), .reset_n(reset_n), .cmd_valid(cmd_valid & sel), .cmd_ready(rdy1),
    .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(err1), .busy(busy1),
    .mdc(mdc1), .mdio_out(mo1), .mdio_oe(oe1), .mdio_in(mdio_in));

  logic cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_out, mdio_oe;
  logic [15:0] rsp_data;
  assign cmd_ready = sel ? rdy1  : rdy0;
  assign rsp_valid = sel ? rv1   : rv0;
  assign rsp_data  = sel ? rd1   : rd0;
  assign rsp_err   = sel ? err1  : err0;
  assign busy      = sel ? busy1 : busy0;
  assign mdc       = sel ? mdc1  : mdc0;
  assign mdio_out  = sel ? mo1   : mo0;
  assign mdio_oe   = sel ? oe1   : oe0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command (called just after a negedge) and check the whole transaction.
  // abort_bit >= 0 pulses reset once that frame bit is on the wire.
  task automatic run_cmd(input bit c45, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd, input bit drv,
                         input bit ta_ok, input logic [15:0] pd, input int abort_bit);
    int div, pb, n, bound, cyc, last_fall, k, per_err, stab_err, idle_oe, fo, foe, rv_seen;
    bit illegal, rd, got, prev_mdc, lo, loe;
    bit q_out[$], q_oe[$], e_out[$], e_oe[$];
    logic [15:0] exp_data, obs_data;
    logic exp_err, obs_err;
    div = sel ? 4 : 2;
    pb  = sel ? 0 : 32;
    illegal = !c45 && (op == 2'b00 || op == 2'b11);
    rd = op[1];
    n  = illegal ? 0 : pb + 32;
    if (!illegal) begin
      for (int i = 0; i < pb; i++) e_out.push_back(1'b1);
      e_out.push_back(1'b0); e_out.push_back(!c45);
      for (int i = 1; i >= 0; i--) e_out.push_back(op[i]);
      for (int i = 4; i >= 0; i--) e_out.push_back(pa[i]);
      for (int i = 4; i >= 0; i--) e_out.push_back(ra[i]);
      e_out.push_back(1'b1); e_out.push_back(1'b0);
      for (int i = 15; i >= 0; i--) e_out.push_back(wd[i]);
      for (int i = 0; i < n; i++) e_oe.push_back(!rd || i < pb + 14);
    end
    exp_data = (illegal || !rd) ? 16'h0 : (drv ? pd : 16'hFFFF);
    exp_err  = illegal || (rd && !(drv && ta_ok));
    bound    = illegal ? 1 : 2*div + n*2*div + 1;

    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_c45 = c45; cmd_op = op; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_c45 = 1'($urandom); cmd_op = 2'($urandom); cmd_phyad = 5'($urandom);
    cmd_regad = 5'($urandom); cmd_wdata = 16'($urandom);
    prev_mdc = mdc; got = 0; cyc = 0; last_fall = -1;
    per_err = 0; stab_err = 0; idle_oe = 0; lo = 1'b1; loe = 1'b0;
    obs_data = '0; obs_err = 1'b0;
    while (!got && cyc < bound + 8) begin
      @(negedge clk); cyc++;
      if (rsp_valid) begin
        got = 1; obs_data = rsp_data; obs_err = rsp_err;
        chk("ready_in_done", 32'(cmd_ready), 0);
      end else if (busy) begin
        if (prev_mdc && !mdc) begin
          if (last_fall >= 0 && cyc - last_fall != 2*div) per_err++;
          last_fall = cyc;
          k = q_out.size();
          lo = mdio_out; loe = mdio_oe;
          q_out.push_back(lo); q_oe.push_back(loe);
          if (rd && drv)
            mdio_in = (k == pb + 15) ? !ta_ok : ((k >= pb + 16) ? pd[15 - (k - pb - 16)] : 1'b1);
          if (abort_bit >= 0 && k == abort_bit) begin
            chk("oe_before_rst", 32'(mdio_oe), 32'(e_oe[k]));
            #2 reset_n = 1'b0;
            #1;
            chk("rst_oe", 32'(mdio_oe), 0);
            chk("rst_out", 32'(mdio_out), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(cmd_ready), 1);
            chk("rst_mdc", 32'(mdc), 0);
            mdio_in = 1'b1;
            rv_seen = 0;
            repeat (3) begin @(negedge clk); if (rsp_valid) rv_seen++; end
            reset_n = 1'b1;
            repeat (bound) begin @(negedge clk); if (rsp_valid) rv_seen++; end
            chk("rst_no_rsp", 32'(rv_seen), 0);
            chk("rst_ready_after", 32'(cmd_ready), 1);
            return;
          end
        end else if (last_fall >= 0 && (mdio_out !== lo || mdio_oe !== loe)) begin
          stab_err++;
        end
      end else if (mdio_oe) begin
        idle_oe++;
      end
      prev_mdc = mdc;
    end
    mdio_in = 1'b1;
    chk("rsp_seen", 32'(got), 1);
    chk("lat_max", 32'(cyc <= bound), 1);
    if (!illegal) chk("lat_min", 32'(cyc >= n*2*div + 2), 1);
    chk("nbits", 32'(q_out.size()), 32'(n));
    fo = 0; foe = 0;
    for (int i = 0; i < n && i < q_out.size(); i++) begin
      if (e_oe[i] && q_out[i] != e_out[i]) fo++;
      if (q_oe[i] != e_oe[i]) foe++;
    end
    chk("frame_bits", 32'(fo), 0);
    chk("frame_oe", 32'(foe), 0);
    chk("bit_period", 32'(per_err), 0);
    chk("bit_stable", 32'(stab_err), 0);
    chk("idle_oe", 32'(idle_oe), 0);
    chk("rsp_data", 32'(obs_data), 32'(exp_data));
    chk("rsp_err", 32'(obs_err), 32'(exp_err));
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 0);
    chk("ready_after", 32'(cmd_ready), 1);
    chk("data_hold", 32'(rsp_data), 32'(exp_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_mdc0", 32'(mdc), 0);
    chk("rst_out0", 32'(mdio_out), 1);
    chk("rst_oe0", 32'(mdio_oe), 0);
    chk("rst_ready0", 32'(cmd_ready), 1);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_rv0", 32'(rsp_valid), 0);
    chk("rst_data0", 32'(rsp_data), 0);
    chk("rst_err0", 32'(rsp_err), 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);

    sel = 0;
    run_cmd(1'b0, 2'b01, 5'h03, 5'h00, 16'h1140, 1'b1, 1'b1, 16'h0000, -1);
    run_cmd(1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 1'b1, 16'h0141, -1);
    run_cmd(1'b1, 2'b00, 5'h00, 5'h01, 16'h0007, 1'b1, 1'b1, 16'h0000, -1);
    run_cmd(1'b1, 2'b11, 5'h00, 5'h01, 16'h0000, 1'b1, 1'b1, 16'hBEEF, -1);
    run_cmd(1'b0, 2'b10, 5'h05, 5'h01, 16'h0000, 1'b0, 1'b1, 16'h0000, -1);
    run_cmd(1'b0, 2'b11, 5'h02, 5'h03, 16'hA5A5, 1'b1, 1'b1, 16'h0000, -1);
    run_cmd(1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 1'b1, 16'h1234, 20);
    sel = 1;
    run_cmd(1'b0, 2'b01, 5'h03, 5'h00, 16'h1140, 1'b1, 1'b1, 16'h0000, -1);
    run_cmd(1'b1, 2'b10, 5'h1F, 5'h07, 16'h0000, 1'b1, 1'b0, 16'h5AC3, -1);

    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom);
      run_cmd(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 16'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
